edge_row_scanner: RTL

//  Sequences the EdgeCache for the Dijkstra core. On request, streams every outgoing edge of one

---
 rtl/edge_row_scanner_pkg.sv | 21 ++
 rtl/edge_row_scanner_if.sv | 27 ++
 rtl/edge_row_scanner_skid.sv | 82 ++++++++
 rtl/edge_row_scanner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/edge_row_scanner_pkg.sv
// edge_row_scanner_pkg
//  Shared constants and types for the edge row scanner slice.
//  - DEFAULT_* : default geometry (nodes per graph, index width, weight width)
//  - EDGE_NONE : weight bit pattern meaning "no edge" (+inf, IEEE-754 single)
//  - ers_state_t : scanner FSM state encoding
package edge_row_scanner_pkg;

    localparam int DEFAULT_MAX_NODES   = 8;
    localparam int DEFAULT_INDEX_WIDTH = 3;
    localparam int DEFAULT_VALUE_WIDTH = 32;

    localparam logic [31:0] EDGE_NONE = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ERS_IDLE  = 2'd0,
        ERS_SCAN  = 2'd1,
        ERS_DRAIN = 2'd2,
        ERS_DONE  = 2'd3
    } ers_state_t;

endpackage

// File: rtl/edge_row_scanner_if.sv
// edge_row_scanner_if
//  Valid/ready edge stream from the scanner to the relax/update stage.
//  Ports (signals): edge_valid, edge_ready, edge_to, edge_weight.
//  master = producer (scanner), slave = consumer.
interface edge_row_scanner_if #(
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 32
) ();
    logic                   edge_valid;
    logic                   edge_ready;
    logic [INDEX_WIDTH-1:0] edge_to;
    logic [VALUE_WIDTH-1:0] edge_weight;

    modport master (
        output edge_valid,
        output edge_to,
        output edge_weight,
        input  edge_ready
    );

    modport slave (
        input  edge_valid,
        input  edge_to,
        input  edge_weight,
        output edge_ready
    );
endinterface

// File: rtl/edge_row_scanner_skid.sv
// edge_skid_buffer
//  Two-entry valid/ready FIFO holding {to_node, weight} pairs between the
//  cache return path and the edge output.
//  Ports: clock, reset (sync, active-low), in_valid/in_to/in_weight (push side),
//         out_valid/out_ready/out_to/out_weight (pop side), empty, count.
//  A push while full is dropped; the caller's credit scheme prevents that.
//  Output data is forced to zero while empty so idle outputs read as 0.
module edge_skid_buffer #(
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [INDEX_WIDTH-1:0] in_to,
    input  logic [VALUE_WIDTH-1:0] in_weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_to,
    output logic [VALUE_WIDTH-1:0] out_weight,
    output logic                   empty,
    output logic [1:0]             count
);
    logic [1:0] count_reg;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic       push;
    logic       pop;

    logic [INDEX_WIDTH-1:0] ent_to [2];
    logic [VALUE_WIDTH-1:0] ent_wt [2];

    assign push = in_valid && (count_reg != 2'd2);
    assign pop  = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [INDEX_WIDTH-1:0] to_reg;
            logic [VALUE_WIDTH-1:0] wt_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    to_reg <= '0;
                    wt_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    to_reg <= in_to;
                    wt_reg <= in_weight;
                end
            end

            assign ent_to[gi] = to_reg;
            assign ent_wt[gi] = wt_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_valid  = (count_reg != 2'd0);
    assign out_to     = out_valid ? ent_to[rd_ptr_reg] : '0;
    assign out_weight = out_valid ? ent_wt[rd_ptr_reg] : '0;
    assign empty      = (count_reg == 2'd0);
    assign count      = count_reg;
endmodule

// File: rtl/edge_row_scanner.sv
// edge_row_scanner
//  Streams all outgoing edges of one source node from the edge cache, in
//  ascending to_node order, and shares the cache's single port with the
//  graph loader.
//  Ports:
//   clock, reset            single clock, synchronous active-low reset
//   cfg_num_nodes           active node count, sampled at scan start
//   scan_start/scan_src     start pulse and source row
//   scan_busy/scan_done     status; done is a one-cycle pulse
//   ld_valid/ld_ready/ld_*  loader write port
//   edge_out                valid/ready edge stream (master side)
//   ec_*                    edge cache port; ec_edge_value returns 1 cycle after a read
module edge_row_scanner
    import edge_row_scanner_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int SKIP_NONE   = 1,
    parameter int SKIP_SELF   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH:0]   cfg_num_nodes,
    input  logic                   scan_start,
    input  logic [INDEX_WIDTH-1:0] scan_src,
    output logic                   scan_busy,
    output logic                   scan_done,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INDEX_WIDTH-1:0] ld_from,
    input  logic [INDEX_WIDTH-1:0] ld_to,
    input  logic [VALUE_WIDTH-1:0] ld_data,
    edge_row_scanner_if.master     edge_out,
    output logic [INDEX_WIDTH-1:0] ec_from_node,
    output logic [INDEX_WIDTH-1:0] ec_to_node,
    output logic                   ec_read_enable,
    output logic                   ec_write_enable,
    output logic [VALUE_WIDTH-1:0] ec_write_data,
    input  logic [VALUE_WIDTH-1:0] ec_edge_value
);
    localparam logic [INDEX_WIDTH:0]   MAX_N     = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [VALUE_WIDTH-1:0] NONE_BITS = VALUE_WIDTH'(EDGE_NONE);

    ers_state_t             state_reg;
    logic [INDEX_WIDTH:0]   col_reg;    // one bit wider so a full row never wraps
    logic [INDEX_WIDTH:0]   n_reg;
    logic [INDEX_WIDTH-1:0] src_reg;
    logic                   ret_valid_reg;
    logic [INDEX_WIDTH-1:0] ret_col_reg;

    logic       read_fire;
    logic       write_fire;
    logic       drop;
    logic       push;
    logic       pop;
    logic [2:0] occ_next;
    logic       credit_ok;
    logic       last_col;
    logic       drained;
    logic       skid_empty;
    logic [1:0] skid_count;

    // Return filtering: discard "no edge" values and the self loop before buffering.
    assign drop = ((SKIP_NONE != 0) && (ec_edge_value == NONE_BITS)) ||
                  ((SKIP_SELF != 0) && (ret_col_reg == src_reg));
    assign push = ret_valid_reg && !drop;
    assign pop  = edge_out.edge_valid && edge_out.edge_ready;

    // Skid occupancy at the end of this cycle. A read issued now lands one
    // cycle later, so it is only safe if at most one slot is taken by then.
    assign occ_next  = {1'b0, skid_count} + {2'b00, push} - {2'b00, pop};
    assign credit_ok = (occ_next <= 3'd1);

    assign read_fire  = (state_reg == ERS_SCAN) && (n_reg != '0) && credit_ok;
    assign ld_ready   = reset && (state_reg == ERS_IDLE) && !scan_start;
    assign write_fire = ld_valid && ld_ready;
    assign last_col   = (col_reg == (n_reg - 1'b1));

    // Nothing in flight and the buffer empties this cycle.
    assign drained = !ret_valid_reg && (skid_empty || ((skid_count == 2'd1) && pop));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ERS_IDLE;
            col_reg       <= '0;
            n_reg         <= '0;
            src_reg       <= '0;
            ret_valid_reg <= 1'b0;
            ret_col_reg   <= '0;
        end else begin
            ret_valid_reg <= read_fire;
            ret_col_reg   <= col_reg[INDEX_WIDTH-1:0];
            case (state_reg)
                ERS_IDLE: begin
                    if (scan_start) begin
                        src_reg   <= scan_src;
                        n_reg     <= (cfg_num_nodes > MAX_N) ? MAX_N : cfg_num_nodes;
                        col_reg   <= '0;
                        state_reg <= ERS_SCAN;
                    end
                end
                ERS_SCAN: begin
                    if (n_reg == '0) begin
                        state_reg <= ERS_DONE;
                    end else if (read_fire) begin
                        col_reg <= col_reg + 1'b1;
                        if (last_col) begin
                            state_reg <= ERS_DRAIN;
                        end
                    end
                end
                ERS_DRAIN: begin
                    if (drained) begin
                        state_reg <= ERS_DONE;
                    end
                end
                ERS_DONE: begin
                    state_reg <= ERS_IDLE;
                end
                default: begin
                    state_reg <= ERS_IDLE;
                end
            endcase
        end
    end

    edge_skid_buffer #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (push),
        .in_to      (ret_col_reg),
        .in_weight  (ec_edge_value),
        .out_valid  (edge_out.edge_valid),
        .out_ready  (edge_out.edge_ready),
        .out_to     (edge_out.edge_to),
        .out_weight (edge_out.edge_weight),
        .empty      (skid_empty),
        .count      (skid_count)
    );

    assign scan_busy = (state_reg != ERS_IDLE);
    assign scan_done = (state_reg == ERS_DONE);

    // Cache port mux: reads only happen in SCAN, writes only in IDLE.
    assign ec_read_enable  = read_fire;
    assign ec_write_enable = write_fire;
    assign ec_from_node    = read_fire ? src_reg :
                             (write_fire ? ld_from : '0);
    assign ec_to_node      = read_fire ? col_reg[INDEX_WIDTH-1:0] :
                             (write_fire ? ld_to : '0);
    assign ec_write_data   = write_fire ? ld_data : '0;
endmodule
